// File: rtl/cdb_multi_pkg.sv
// Shared CDB definitions: default widths, lane count and the broadcast lane record
// consumed by the reservation stations, ROB and map table.
package cdb_multi_pkg;

  localparam int TAG_W_DEF   = 5;
  localparam int XLEN_DEF    = 32;
  localparam int NUM_CDB_DEF = 2;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_DEF-1:0] rob_tag;
    logic [XLEN_DEF-1:0]  value;
  } cdb_lane_t;

  // Pointer width that stays legal when there is only one requester.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_multi_rr_multi_sel.sv
// Combinational multi-grant selector: picks the first NUM_LANE requesters in
// round-robin (from ptr) or fixed (highest index first) order; lane k gets the k-th grant.
module rr_multi_sel
  import cdb_multi_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int NUM_LANE = 2,
  localparam int PW      = ptr_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]                req,
  input  logic [PW-1:0]                     ptr,
  input  logic                              rr_mode,
  output logic [NUM_REQ-1:0]                grant,
  output logic [NUM_LANE-1:0][NUM_REQ-1:0]  lane_onehot,
  output logic [NUM_LANE-1:0]               lane_valid,
  output logic [PW-1:0]                     last_idx,
  output logic                              any_grant
);

  always_comb begin
    int  idx;
    int  cnt;
    logic hit;
    grant       = '0;
    lane_onehot = '0;
    lane_valid  = '0;
    last_idx    = '0;
    any_grant   = 1'b0;
    cnt         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = rr_mode ? ((int'(ptr) + k) % NUM_REQ) : (NUM_REQ - 1 - k);
      hit = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == idx) hit = req[i];
      end
      // Matching against constant loop indices keeps every select statically sized.
      if (hit && (cnt < NUM_LANE)) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (i == idx) grant[i] = 1'b1;
        end
        for (int l = 0; l < NUM_LANE; l++) begin
          if (l == cnt) begin
            lane_valid[l] = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
              if (i == idx) lane_onehot[l][i] = 1'b1;
            end
          end
        end
        last_idx  = PW'(idx);
        any_grant = 1'b1;
        cnt       = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/cdb_multi.sv
// Multi-lane common data bus: arbitrates FU completions onto NUM_CDB registered
// broadcast lanes. Handshake: fu_done[i] with stable tag/value is consumed in the cycle fu_ack[i]=1.
module cdb_multi
  import cdb_multi_pkg::*;
#(
  parameter int NUM_FU  = 4,
  parameter int NUM_CDB = NUM_CDB_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int XLEN    = XLEN_DEF,
  parameter int RR_MODE = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic [NUM_FU-1:0]         fu_done,
  input  logic [NUM_FU*TAG_W-1:0]   fu_rob_tag,
  input  logic [NUM_FU*XLEN-1:0]    fu_value,
  output logic [NUM_FU-1:0]         fu_ack,
  output logic [NUM_CDB-1:0]        cdb_valid,
  output logic [NUM_CDB*TAG_W-1:0]  cdb_rob_tag,
  output logic [NUM_CDB*XLEN-1:0]   cdb_value
);

  localparam int PTR_W = ptr_w(NUM_FU);

  logic [PTR_W-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [NUM_CDB-1:0]               valid_q, valid_d;
  logic [NUM_CDB*TAG_W-1:0]         tag_q, tag_d;
  logic [NUM_CDB*XLEN-1:0]          value_q, value_d;

  logic [NUM_FU-1:0]                grant;
  logic [NUM_CDB-1:0][NUM_FU-1:0]   lane_onehot;
  logic [NUM_CDB-1:0]               lane_valid;
  logic [PTR_W-1:0]                 last_idx;
  logic                             any_grant;
  logic                             flush;

  assign flush = reset | clear;

  rr_multi_sel #(
    .NUM_REQ  (NUM_FU),
    .NUM_LANE (NUM_CDB)
  ) u_sel (
    .req         (fu_done),
    .ptr         (rr_ptr_q),
    .rr_mode     (RR_MODE != 0),
    .grant       (grant),
    .lane_onehot (lane_onehot),
    .lane_valid  (lane_valid),
    .last_idx    (last_idx),
    .any_grant   (any_grant)
  );

  // A flush cycle grants nothing, so the FUs keep holding their results.
  assign fu_ack = flush ? '0 : grant;

  always_comb begin
    valid_d = '0;
    tag_d   = '0;
    value_d = '0;
    if (!flush) begin
      for (int l = 0; l < NUM_CDB; l++) begin
        valid_d[l] = lane_valid[l];
        for (int i = 0; i < NUM_FU; i++) begin
          if (lane_onehot[l][i]) begin
            tag_d[l*TAG_W +: TAG_W] = fu_rob_tag[i*TAG_W +: TAG_W];
            value_d[l*XLEN +: XLEN] = fu_value[i*XLEN +: XLEN];
          end
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (flush || (RR_MODE == 0)) begin
      rr_ptr_d = '0;
    end else if (any_grant) begin
      // Explicit wrap: NUM_FU need not be a power of two.
      rr_ptr_d = (last_idx == PTR_W'(NUM_FU - 1)) ? '0 : last_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q <= '0;
      valid_q  <= '0;
      tag_q    <= '0;
      value_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      value_q  <= value_d;
    end
  end

  assign cdb_valid   = valid_q;
  assign cdb_rob_tag = tag_q;
  assign cdb_value   = value_q;

endmodule

// File: tb/tb_cdb_multi.sv
// Bench for cdb_multi: a round-robin and a fixed-priority instance share the FU stimulus;
// a reference model predicts acks and pushes expected lane contents to per-instance queues.
module tb_cdb_multi;

  localparam int NUM_FU  = 4;
  localparam int NUM_CDB = 2;
  localparam int TAG_W   = 5;
  localparam int XLEN    = 32;
  localparam int EW      = NUM_CDB * (1 + TAG_W + XLEN);

  logic                      clock;
  logic                      reset;
  logic                      clear;
  logic [NUM_FU-1:0]         fu_done;
  logic [NUM_FU*TAG_W-1:0]   fu_rob_tag;
  logic [NUM_FU*XLEN-1:0]    fu_value;
  logic [NUM_FU-1:0]         fu_ack, fu_ack_fp;
  logic [NUM_CDB-1:0]        cdb_valid, cdb_valid_fp;
  logic [NUM_CDB*TAG_W-1:0]  cdb_rob_tag, cdb_rob_tag_fp;
  logic [NUM_CDB*XLEN-1:0]   cdb_value, cdb_value_fp;

  logic [TAG_W-1:0] tag_a [NUM_FU];
  logic [XLEN-1:0]  val_a [NUM_FU];

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_fp_q[$];
  logic [1:0]    m_ptr;
  logic [3:0]    m_ack;
  int            wait_cnt [NUM_FU];
  int            n_cmp;
  int            n_err;

  cdb_multi #(.NUM_FU(NUM_FU), .NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .XLEN(XLEN), .RR_MODE(1)) dut (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .fu_done     (fu_done),
    .fu_rob_tag  (fu_rob_tag),
    .fu_value    (fu_value),
    .fu_ack      (fu_ack),
    .cdb_valid   (cdb_valid),
    .cdb_rob_tag (cdb_rob_tag),
    .cdb_value   (cdb_value)
  );

  cdb_multi #(.NUM_FU(NUM_FU), .NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .XLEN(XLEN), .RR_MODE(0)) dut_fp (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .fu_done     (fu_done),
    .fu_rob_tag  (fu_rob_tag),
    .fu_value    (fu_value),
    .fu_ack      (fu_ack_fp),
    .cdb_valid   (cdb_valid_fp),
    .cdb_rob_tag (cdb_rob_tag_fp),
    .cdb_value   (cdb_value_fp)
  );

  // clock/reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always_comb begin
    fu_rob_tag = '0;
    fu_value   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_rob_tag[i*TAG_W +: TAG_W] = tag_a[i];
      fu_value[i*XLEN +: XLEN]     = val_a[i];
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Reference arbiter: walks the priority order and fills lanes in order.
  function automatic void model(input logic [3:0] done, input logic [1:0] ptr, input bit rr,
                                input bit flush, output logic [3:0] ack,
                                output logic [EW-1:0] lanes, output logic [1:0] nptr);
    int n = 0;
    int idx;
    logic [NUM_CDB-1:0]       v = '0;
    logic [NUM_CDB*TAG_W-1:0] t = '0;
    logic [NUM_CDB*XLEN-1:0]  x = '0;
    ack  = '0;
    nptr = rr ? ptr : 2'd0;
    if (flush) begin
      nptr = 2'd0;
    end else begin
      for (int k = 0; k < NUM_FU; k++) begin
        idx = rr ? ((int'(ptr) + k) % NUM_FU) : (NUM_FU - 1 - k);
        if (done[idx] && n < NUM_CDB) begin
          ack[idx]            = 1'b1;
          v[n]                = 1'b1;
          t[n*TAG_W +: TAG_W] = tag_a[idx];
          x[n*XLEN +: XLEN]   = val_a[idx];
          n++;
          if (rr) nptr = 2'((idx + 1) % NUM_FU);
        end
      end
    end
    lanes = {v, t, x};
  endfunction

  // One cycle: compare last cycle's lanes, predict this cycle's acks/lanes, advance the clock.
  task automatic cycle();
    logic [EW-1:0] e;
    logic [3:0]    a;
    logic [1:0]    np;
    @(negedge clock);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("lanes_rr", 128'({cdb_valid, cdb_rob_tag, cdb_value}), 128'(e));
    end
    if (exp_fp_q.size() > 0) begin
      e = exp_fp_q.pop_front();
      check("lanes_fp", 128'({cdb_valid_fp, cdb_rob_tag_fp, cdb_value_fp}), 128'(e));
    end
    model(fu_done, m_ptr, 1'b1, reset | clear, a, e, np);
    check("ack_rr", 128'(fu_ack), 128'(a));
    exp_q.push_back(e);
    m_ptr = np;
    m_ack = a;
    model(fu_done, 2'd0, 1'b0, reset | clear, a, e, np);
    check("ack_fp", 128'(fu_ack_fp), 128'(a));
    exp_fp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] done, input bit rst, input bit clr);
    fu_done = done;
    reset   = rst;
    clear   = clr;
    cycle();
  endtask

  initial begin
    bit was_clr;
    n_cmp   = 0;
    n_err   = 0;
    m_ptr   = 2'd0;
    m_ack   = '0;
    reset   = 1'b1;
    clear   = 1'b0;
    fu_done = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      tag_a[i]    = TAG_W'($urandom_range(0, 31));
      val_a[i]    = $urandom;
      wait_cnt[i] = 0;
    end

    // reset held with all FUs requesting: no acks, lanes cleared
    drive(4'b1111, 1'b1, 1'b0);
    drive(4'b1111, 1'b1, 1'b0);

    // single request on FU2
    tag_a[2] = 5'd5;
    val_a[2] = 32'hDEAD;
    drive(4'b0100, 1'b0, 1'b0);
    drive(4'b0000, 1'b0, 1'b0);

    // back to pointer 0, then all four held: 0011 then 1100
    drive(4'b0000, 1'b1, 1'b0);
    drive(4'b1111, 1'b0, 1'b0);
    drive(4'b1100, 1'b0, 1'b0);

    // move pointer to 3, then wrap with 1001
    drive(4'b0100, 1'b0, 1'b0);
    drive(4'b1001, 1'b0, 1'b0);
    drive(4'b0010, 1'b0, 1'b0);

    // all requesting for three cycles (fixed-priority instance acks 1100 each time)
    drive(4'b1111, 1'b0, 1'b0);
    drive(4'b1111, 1'b0, 1'b0);
    drive(4'b1111, 1'b0, 1'b0);

    // clear with lanes valid and requests pending
    drive(4'b0110, 1'b0, 1'b0);
    drive(4'b0110, 1'b0, 1'b1);
    drive(4'b0110, 1'b0, 1'b0);
    drive(4'b0000, 1'b0, 1'b0);

    // random FUs that hold until acked, occasional clear; checks round-robin fairness
    fu_done = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (!fu_done[i] && $urandom_range(0, 1) == 1) begin
          fu_done[i]  = 1'b1;
          tag_a[i]    = TAG_W'($urandom_range(0, 31));
          val_a[i]    = $urandom;
          wait_cnt[i] = 0;
        end
      end
      was_clr = ($urandom_range(0, 19) == 0);
      clear   = was_clr;
      reset   = 1'b0;
      cycle();
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_done[i]) begin
          if (was_clr) begin
            fu_done[i] = 1'b0;
          end else if (m_ack[i]) begin
            check("fair_rr", 128'(wait_cnt[i] <= 1), 128'(1));
            fu_done[i] = 1'b0;
          end else begin
            wait_cnt[i]++;
          end
        end
      end
    end
    clear   = 1'b0;
    fu_done = '0;
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cdb_multi.md
Name: cdb_multi

Overview:
- Parametrised successor to the single-lane CDB. Arbitrates NUM_FU functional-unit completions onto NUM_CDB parallel broadcast lanes per cycle.
- Supports fixed-priority (legacy) or round-robin arbitration.
- Registers granted results for one-cycle broadcast to the RS, ROB and map table.
- FUs hold done until acked, so a lost arbitration never drops a result.

Parameters:
- NUM_FU, 4, number of requesting functional units (≥1).
- NUM_CDB, 2, broadcast lanes per cycle (1 ≤ NUM_CDB ≤ NUM_FU).
- TAG_W, 5, ROB tag width.
- XLEN, 32, result value width.
- RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority, highest FU index first.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- clear  in  1  synchronous flush (mispredict); same effect as reset.
- fu_done  in  NUM_FU  per-FU result-valid; held until acked.
- fu_rob_tag  in  NUM_FU*TAG_W  per-FU ROB tag, slice i = FU i.
- fu_value  in  NUM_FU*XLEN  per-FU result value.
- fu_ack  out  NUM_FU  combinational grant; FU i may drop/replace its result next cycle.
- cdb_valid  out  NUM_CDB  lane valid, registered.
- cdb_rob_tag  out  NUM_CDB*TAG_W  lane tag, registered.
- cdb_value  out  NUM_CDB*XLEN  lane value, registered.

Behaviour:
- One clock domain: clock. Reset is synchronous and active-high.
- Reset or clear: cdb_valid, cdb_rob_tag, cdb_value = 0; rr_ptr = 0; fu_ack forced to 0 in that cycle, so no grant is consumed.
- Handshake: FU i asserts fu_done[i] with stable tag/value. The request is granted when fu_ack[i]=1 in the same cycle. The FU must hold all three until it sees the ack. An ungranted FU holds with no loss.
- Grant selection is combinational from fu_done and rr_ptr. At most NUM_CDB acks per cycle, chosen as the first NUM_CDB requesters in priority order:
  - RR_MODE=1: order is rr_ptr, rr_ptr+1, … mod NUM_FU.
  - RR_MODE=0: order is NUM_FU-1 down to 0; rr_ptr is ignored and held at 0.
- Lane assignment: the k-th grant in priority order goes to lane k. Lanes with no grant have valid=0, tag=0, value=0.
- Latency: grant at cycle t → lane outputs valid during cycle t+1 only. There is no back-pressure from consumers.
- rr_ptr update (RR_MODE=1, no reset/clear): if ≥1 grant, rr_ptr ← (index of last granted FU + 1) mod NUM_FU; otherwise unchanged. Width is clog2(NUM_FU); wrap is explicit, not natural overflow.
- Fairness: in RR_MODE=1, a continuously asserted fu_done is acked within ceil(NUM_FU/NUM_CDB) cycles. RR_MODE=0 has no starvation bound.
- Simultaneous clear and done: done is ignored and the FU must still hold; the producing FU is itself flushed by clear.
- NUM_CDB == NUM_FU: every asserted done is acked every cycle.
- Duplicate tags on two lanes are not checked; FU correctness is assumed.

Decomposition:
- Shared package (sys_defs): TAG_W and XLEN defaults, CDB lane struct {valid, rob_tag, value}, NUM_CDB define consumed by RS/ROB/map table.
- Sub-module rr_multi_sel: request vector, pointer and mode in; grant vector and per-lane one-hot index out. Purely combinational, reusable for issue select.
- Top level holds rr_ptr, the lane registers and the mux from FU slices to lanes.

Test Plan (NUM_FU=4, NUM_CDB=2, RR_MODE=1 unless noted):
- Reset asserted 2 cycles with fu_done=1111 → fu_ack=0000; cdb_valid=00, tags/values 0; after release rr_ptr=0.
- fu_done=0100, tag[2]=5, value[2]=0xDEAD → fu_ack=0100 same cycle; next cycle lane0 valid, tag 5, value 0xDEAD; lane1 valid=0.
- fu_done=1111 held for all 4 FUs → cycle0 ack=0011, lanes FU0/FU1, rr_ptr→2; cycle1 ack=1100, lanes FU2/FU3, rr_ptr→0.
- Wrap: rr_ptr=3, fu_done=1001 → ack=1001, lane0=FU3, lane1=FU0; rr_ptr→1.
- RR_MODE=0, fu_done=1111 held 3 cycles → ack=1100 every cycle, lane0=FU3, lane1=FU2; FU0/FU1 never acked.
- clear pulsed with fu_done=0110 and lanes valid → fu_ack=0000 that cycle; next cycle cdb_valid=00, rr_ptr=0; following cycle ack=0110.
